// File: rtl/i2c_multibus_recovery.sv
// i2c_multibus_recovery: stuck-bus monitor and bus-clear engine for up to 16
// open-drain I2C busses. Each bus has a stuck-low timer; one shared FSM runs
// the clear sequence (up to MAX_PULSES SCL pulses, then a STOP) on one bus at
// a time. Build option: define I2C_REC_AUTO_EN to let the lowest-index stuck
// bus launch a recovery on its own when no request is pending.
module i2c_multibus_recovery #(
    parameter int NUM_BUSSES = 16,
    parameter int TIMEOUT_W  = 16,
    parameter int DIV_W      = 12,
    parameter int MAX_PULSES = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NUM_BUSSES-1:0] scl_i,
    input  logic [NUM_BUSSES-1:0] sda_i,
    output logic [NUM_BUSSES-1:0] scl_o,
    output logic [NUM_BUSSES-1:0] sda_o,
    input  logic [TIMEOUT_W-1:0]  cfg_timeout,
    input  logic [DIV_W-1:0]      cfg_half_period,
    input  logic                  rec_req,
    input  logic [3:0]            rec_bus,
    output logic [NUM_BUSSES-1:0] stuck,
    output logic                  busy,
    output logic                  done,
    output logic                  rec_ok,
    output logic [3:0]            rec_pulses
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_CHK, ST_SCL_LO, ST_SCL_HI, ST_STOP_A,
        ST_STOP_B, ST_STOP_C, ST_STOP_D, ST_FAIL, ST_DONE
    } state_t;

    logic [NUM_BUSSES-1:0] scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic [TIMEOUT_W-1:0]  cnt_q [NUM_BUSSES];
    logic [TIMEOUT_W-1:0]  cnt_d [NUM_BUSSES];
    logic [NUM_BUSSES-1:0] cond, bus_oh;
    state_t                state_q;
    logic [3:0]            bus_q, pulses_q, rec_pulses_q;
    logic [DIV_W-1:0]      div_q, hp_m1;
    logic [TIMEOUT_W-1:0]  wait_q;
    logic                  hi_ph_q, scl_drv_q, sda_drv_q;
    logic                  busy_q, done_q, rec_ok_q;
    logic                  scl_sel, sda_sel, tmo_hit, req_ok;
    logic                  launch_go;
    logic [3:0]            launch_idx;

    // A bus is "busy-looking" when SCL is low, or SCL is high with SDA low.
    assign cond    = ~scl_s2_q | ~sda_s2_q;
    assign bus_oh  = NUM_BUSSES'(1) << bus_q;
    assign scl_sel = |(scl_s2_q & bus_oh);
    assign sda_sel = |(sda_s2_q & bus_oh);
    // A programmed half period of 0 behaves like 1.
    assign hp_m1   = (cfg_half_period == '0) ? '0 : cfg_half_period - DIV_W'(1);
    // A zero timeout leaves the SCL-high wait unbounded.
    assign tmo_hit = (cfg_timeout != '0) && (wait_q >= cfg_timeout);
    assign req_ok  = rec_req && ({1'b0, rec_bus} < 5'(NUM_BUSSES));

    // Only the selected bus is ever pulled low; every other line stays released.
    assign scl_o      = ~(bus_oh & {NUM_BUSSES{scl_drv_q}});
    assign sda_o      = ~(bus_oh & {NUM_BUSSES{sda_drv_q}});
    assign busy       = busy_q;
    assign done       = done_q;
    assign rec_ok     = rec_ok_q;
    assign rec_pulses = rec_pulses_q;

    // Two-flop synchronisers on every SCL/SDA pin; idle level is released (1).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_s1_q <= '1;
            scl_s2_q <= '1;
            sda_s1_q <= '1;
            sda_s2_q <= '1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
        end
    end

    // Per-bus stuck timers: count while the condition holds, saturate at the threshold.
    always_comb begin
        for (int i = 0; i < NUM_BUSSES; i++) begin
            if ((busy_q && bus_oh[i]) || !cond[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= cfg_timeout) begin
                cnt_d[i] = cfg_timeout;
            end else begin
                cnt_d[i] = cnt_q[i] + TIMEOUT_W'(1);
            end
            stuck[i] = (cfg_timeout != '0) && (cnt_q[i] == cfg_timeout);
        end
    end

    // Register the stuck timers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_BUSSES; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BUSSES; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef I2C_REC_AUTO_EN
    logic [NUM_BUSSES-1:0] mask_q, auto_cand;
    logic                  auto_hit;
    logic [3:0]            auto_idx;

    // Lowest-index stuck bus that has not already failed a recovery.
    always_comb begin
        auto_cand = stuck & ~mask_q;
        auto_hit  = 1'b0;
        auto_idx  = '0;
        for (int i = NUM_BUSSES - 1; i >= 0; i--) begin
            if (auto_cand[i]) begin
                auto_hit = 1'b1;
                auto_idx = 4'(i);
            end
        end
    end

    // A failed bus stays masked until its line condition actually clears.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= (mask_q & ~(~cond & ~(bus_oh & {NUM_BUSSES{busy_q}})))
                    | (bus_oh & {NUM_BUSSES{state_q == ST_FAIL}});
        end
    end

    // Explicit request wins over an automatic launch in the same cycle.
    always_comb begin
        launch_go  = req_ok || auto_hit;
        launch_idx = req_ok ? rec_bus : auto_idx;
    end
`else
    // Recovery starts only from an explicit request.
    always_comb begin
        launch_go  = req_ok;
        launch_idx = rec_bus;
    end
`endif

    // Shared recovery FSM: SCL pulses until SDA frees, then a STOP, one bus at a time.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            bus_q        <= '0;
            pulses_q     <= '0;
            rec_pulses_q <= '0;
            div_q        <= '0;
            wait_q       <= '0;
            hi_ph_q      <= 1'b0;
            scl_drv_q    <= 1'b0;
            sda_drv_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rec_ok_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (launch_go) begin
                        bus_q    <= launch_idx;
                        busy_q   <= 1'b1;
                        pulses_q <= '0;
                        state_q  <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (sda_sel) begin
                        scl_drv_q <= 1'b1;
                        div_q     <= hp_m1;
                        state_q   <= ST_STOP_A;
                    end else if (pulses_q == 4'(MAX_PULSES)) begin
                        state_q <= ST_FAIL;
                    end else begin
                        scl_drv_q <= 1'b1;
                        div_q     <= hp_m1;
                        state_q   <= ST_SCL_LO;
                    end
                end
                ST_SCL_LO, ST_STOP_B: begin
                    if (div_q == '0) begin
                        scl_drv_q <= 1'b0;
                        wait_q    <= '0;
                        hi_ph_q   <= 1'b0;
                        state_q   <= (state_q == ST_SCL_LO) ? ST_SCL_HI : ST_STOP_C;
                    end else begin
                        div_q <= div_q - DIV_W'(1);
                    end
                end
                ST_SCL_HI, ST_STOP_C: begin
                    if (!hi_ph_q) begin
                        // Wait out clock stretching before timing the high phase.
                        if (scl_sel) begin
                            hi_ph_q <= 1'b1;
                            div_q   <= hp_m1;
                        end else if (tmo_hit) begin
                            state_q <= ST_FAIL;
                        end else begin
                            wait_q <= wait_q + TIMEOUT_W'(1);
                        end
                    end else if (div_q != '0) begin
                        div_q <= div_q - DIV_W'(1);
                    end else if (state_q == ST_SCL_HI) begin
                        pulses_q <= pulses_q + 4'd1;
                        state_q  <= ST_CHK;
                    end else begin
                        sda_drv_q <= 1'b0;
                        div_q     <= hp_m1;
                        state_q   <= ST_STOP_D;
                    end
                end
                ST_STOP_A: begin
                    if (div_q == '0) begin
                        sda_drv_q <= 1'b1;
                        div_q     <= hp_m1;
                        state_q   <= ST_STOP_B;
                    end else begin
                        div_q <= div_q - DIV_W'(1);
                    end
                end
                ST_STOP_D: begin
                    if (div_q != '0) begin
                        div_q <= div_q - DIV_W'(1);
                    end else if (sda_sel) begin
                        rec_ok_q <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        state_q <= ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    rec_ok_q  <= 1'b0;
                    scl_drv_q <= 1'b0;
                    sda_drv_q <= 1'b0;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    rec_pulses_q <= pulses_q;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
